alu_nibble_sequencer: RTL and testbench

- Initiator-side controller for the combinational 4-bit ALU. It accepts wide operand requests over a valid/ready handshake.
- It issues one 4-bit ALU operation per clock, least-significant nibble first. The ALU carry or borrow output is chained back into the ALU carry or borrow input on the next cycle.
- It assembles the wide result and flags, then returns them over a valid/ready response handshake.
- The ALU is instantiated beside this block, not inside it. This block drives all ALU inputs and samples all ALU outputs.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_nibble_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: request opcodes,
// ALU control encodings and the sequencer FSM state encoding.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CMP  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Initiator-side controller for an external combinational 4-bit ALU.
// Accepts wide ADD/SUB/CMP requests, walks them through the ALU one nibble
// per clock (LSB first, carry/borrow chained), and returns the assembled
// result and flags over a valid/ready response handshake.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic                   req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_result,
    output logic                   rsp_cout,
    output logic                   rsp_lt,
    output logic                   rsp_eq,
    output logic                   rsp_gt,
    output logic                   rsp_err,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_control,
    output logic                   alu_c_in,
    output logic                   alu_b_in,
    input  logic [3:0]             alu_c,
    input  logic                   alu_c_out,
    input  logic                   alu_b_out
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    op_t                op_q;
    logic [W-1:0]       a_q, b_q, result_q, res_next;
    logic [IDX_W-1:0]   idx_q;
    logic               chain_q, chain_next;
    logic               is_cmp, lt_raw, eq_raw;

    // State register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid)
                         state_d = (op_t'(req_op) == OP_RSVD) ? ST_RESP : ST_RUN;
            ST_RUN:  if (idx_q == LAST_IDX) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and ALU drive; the ALU sees idle inputs outside RUN.
    always_comb begin
        req_ready   = (state_q == ST_IDLE) && rst_n;
        rsp_valid   = (state_q == ST_RESP);
        alu_a       = 4'h0;
        alu_b       = 4'h0;
        alu_control = ALU_PASS;
        alu_c_in    = 1'b0;
        alu_b_in    = 1'b0;
        if (state_q == ST_RUN) begin
            alu_a = a_q[{idx_q, 2'b00} +: 4];
            alu_b = b_q[{idx_q, 2'b00} +: 4];
            if (op_q == OP_ADD) begin
                alu_control = ALU_ADD;
                alu_c_in    = chain_q;
            end else begin
                alu_control = ALU_SUB;
                alu_b_in    = chain_q;
            end
        end
    end

    // Result with the current ALU nibble merged in, plus the outgoing chain bit
    // and CMP flags as they will stand after this RUN edge.
    always_comb begin
        res_next                      = result_q;
        res_next[{idx_q, 2'b00} +: 4] = alu_c;
        chain_next = (op_q == OP_ADD) ? alu_c_out : alu_b_out;
        is_cmp     = (op_q == OP_CMP);
        lt_raw     = chain_next;
        eq_raw     = (res_next == '0);
    end

    // Operand capture, nibble accumulation and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            idx_q      <= '0;
            chain_q    <= 1'b0;
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    op_q     <= op_t'(req_op);
                    a_q      <= req_a;
                    b_q      <= req_b;
                    chain_q  <= (op_t'(req_op) == OP_CMP) ? 1'b0 : req_cin;
                    idx_q    <= '0;
                    result_q <= '0;
                    if (op_t'(req_op) == OP_RSVD) begin
                        rsp_result <= '0;
                        rsp_cout   <= 1'b0;
                        rsp_lt     <= 1'b0;
                        rsp_eq     <= 1'b0;
                        rsp_gt     <= 1'b0;
                        rsp_err    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    result_q <= res_next;
                    chain_q  <= chain_next;
                    idx_q    <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        rsp_result <= res_next;
                        rsp_cout   <= chain_next;
                        rsp_lt     <= is_cmp && lt_raw;
                        rsp_eq     <= is_cmp && eq_raw;
                        rsp_gt     <= is_cmp && !lt_raw && !eq_raw;
                        rsp_err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer: a behavioural 4-bit ALU sits beside the
// sequencer, a table of directed vectors is applied in a loop, and hand-written
// sequences cover backpressure, request blocking and mid-operation reset.
module tb_alu_nibble_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;
    localparam int BOUND   = 20;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = 2'b00;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic           req_cin = 1'b0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_result;
    logic           rsp_cout, rsp_lt, rsp_eq, rsp_gt, rsp_err;
    logic [3:0]     alu_a, alu_b, alu_c;
    logic [2:0]     alu_control;
    logic           alu_c_in, alu_b_in, alu_c_out, alu_b_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         cout;
        logic         lt;
        logic         eq;
        logic         gt;
        logic         err;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt),
        .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_c_in(alu_c_in), .alu_b_in(alu_b_in),
        .alu_c(alu_c), .alu_c_out(alu_c_out), .alu_b_out(alu_b_out)
    );

    // Behavioural model of the external combinational 4-bit ALU.
    always_comb begin
        alu_c     = alu_a;
        alu_c_out = 1'b0;
        alu_b_out = 1'b0;
        case (alu_control)
            3'b001: {alu_c_out, alu_c} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_c_in};
            3'b010: {alu_b_out, alu_c} = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0, alu_b_in};
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("req_ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Watch RUN cycles after acceptance, then check the response fields.
    // Leaves the bench on a negedge with rsp_valid high (unless timed out).
    task automatic collect(input vec_t v);
        int k = 0;
        int drive_bad = 0;
        logic [2:0] exp_ctl;
        logic [W-1:0] av, bv;
        av = v.a;
        bv = v.b;
        exp_ctl = (v.op == 2'b00) ? 3'b001 : 3'b010;
        @(negedge clk);
        while (!rsp_valid && k < BOUND) begin
            if (k < NIBBLES) begin
                if (alu_control !== exp_ctl) drive_bad++;
                if (alu_a !== av[4*k +: 4]) drive_bad++;
                if (alu_b !== bv[4*k +: 4]) drive_bad++;
                if (k == 0) begin
                    if (v.op == 2'b00 && (alu_c_in !== v.cin || alu_b_in !== 1'b0)) drive_bad++;
                    if (v.op == 2'b01 && (alu_b_in !== v.cin || alu_c_in !== 1'b0)) drive_bad++;
                    if (v.op == 2'b10 && (alu_b_in !== 1'b0 || alu_c_in !== 1'b0)) drive_bad++;
                end
            end
            @(negedge clk);
            k++;
        end
        check("run_cycles", 64'(k), (v.op == 2'b11) ? 64'd0 : 64'(NIBBLES));
        check("alu_drive", 64'(drive_bad), 64'd0);
        if (v.op == 2'b11) check("rsvd_alu_control", 64'(alu_control), 64'd0);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_result", 64'(rsp_result), 64'(v.res));
        check("rsp_flags", 64'({rsp_cout, rsp_lt, rsp_eq, rsp_gt, rsp_err}),
              64'({v.cout, v.lt, v.eq, v.gt, v.err}));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [W-1:0] held;
        //            op     a        b        cin   res      cout lt   eq   gt   err
        vecs[0]  = '{2'b00, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b00, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{2'b01, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b01, 16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{2'b10, 16'h00A5, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b10, 16'h0001, 16'h0100, 1'b0, 16'hFF01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{2'b10, 16'h00A5, 16'h00A5, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state.
        #12;
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_outputs", 64'({rsp_valid, rsp_result, rsp_cout, rsp_lt, rsp_eq,
                                    rsp_gt, rsp_err, alu_a, alu_b, alu_control,
                                    alu_c_in, alu_b_in}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("idle_req_ready", 64'(req_ready), 64'd1);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            collect(vecs[i]);
            handshake();
        end

        // Backpressure: hold the response for 3 cycles with a request pending.
        issue(2'b00, 16'h0001, 16'h0002, 1'b0);
        collect('{2'b00, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        held      = rsp_result;
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_a     = 16'h00A5;
        req_b     = 16'h00A5;
        req_cin   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_stable", 64'({rsp_result, rsp_cout, rsp_lt, rsp_eq, rsp_gt, rsp_err}),
                  64'({held, 5'b00000}));
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
        check("post_hs_rsp_kept", 64'(rsp_result), 64'(held));
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("accept_req_ready", 64'(req_ready), 64'd0);
        check("accept_alu_control", 64'(alu_control), 64'd2);
        collect('{2'b10, 16'h00A5, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        handshake();

        // Asynchronous reset during the second RUN cycle.
        issue(2'b00, 16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_req_ready", 64'(req_ready), 64'd0);
        check("midrun_reset_outputs", 64'({rsp_valid, rsp_result, rsp_cout, rsp_lt, rsp_eq,
                                           rsp_gt, rsp_err, alu_a, alu_b, alu_control,
                                           alu_c_in, alu_b_in}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_req_ready", 64'(req_ready), 64'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("no_rsp_after_abort", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
